cozy_bus_decoder: RTL and testbench

Parametrised address decoder and read-data multiplexer for the cozy CPU bus. It sits between `cozy_cpu` and up to eight memory-mapped slaves such as `cozy_memory` and `debug_adapter`, replacing hand-written per-slave chip-enable and read-mux logic in board top levels. It produces gated byte-write enables per slave and selects slave read data with the CPU's one-cycle read latency. It also records writes to unmapped addresses in a sticky fault register that software or a debug adapter can read.

---
 rtl/cozy_bus_decoder.sv | 126 ++++++++++++
 tb/tb_cozy_bus_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cozy_bus_decoder.sv
// Address decoder and read-data mux for the cozy CPU bus: one-hot slave enables,
// gated byte-write enables, one-cycle read select and a sticky unmapped-write fault log.
module cozy_bus_decoder #(
  parameter int                NCH           = 2,
  parameter logic [NCH*16-1:0] REGION_BASE   = {16'hff80, 16'h0000},
  parameter logic [NCH*5-1:0]  REGION_BITS   = {5'd7, 5'd13},
  parameter logic [15:0]       UNMAPPED_DATA = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic [1:0]        cpu_bwe,
  output logic [15:0]       cpu_drd,
  output logic [NCH-1:0]    slv_ce,
  output logic [2*NCH-1:0]  slv_bwe,
  input  logic [16*NCH-1:0] slv_drd,
  output logic              fault,
  output logic [15:0]       fault_addr,
  output logic [7:0]        fault_count,
  input  logic              fault_clear
);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("cozy_bus_decoder: NCH must be in 1..8");
  end

  logic [NCH-1:0] hit;

  // Each channel matches on the address bits above its region size.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int          BITS      = int'(REGION_BITS[5*i +: 5]);
    localparam logic [15:0] BASE      = REGION_BASE[16*i +: 16];
    localparam logic [16:0] SPAN_MASK = (17'd1 << BITS) - 17'd1;
    localparam logic [15:0] LOW_MASK  = SPAN_MASK[15:0];

    if (BITS > 16) begin : g_bad_bits
      $error("cozy_bus_decoder: REGION_BITS exceeds 16");
    end
    if ((BASE & LOW_MASK) != 16'h0000) begin : g_bad_base
      $error("cozy_bus_decoder: region base not aligned to region size");
    end

    assign hit[i] = ((cpu_addr ^ BASE) & ~LOW_MASK) == 16'h0000;
  end

  // Lowest-indexed hit wins.
  always_comb begin
    logic found;
    slv_ce = '0;
    found  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (hit[i] && !found) begin
        slv_ce[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    slv_bwe = '0;
    for (int i = 0; i < NCH; i++) begin
      slv_bwe[2*i +: 2] = slv_ce[i] ? cpu_bwe : 2'b00;
    end
  end

  logic [NCH-1:0] sel_d, sel_q;

  assign sel_d = slv_ce;

  // sel_q is one-hot or zero, so OR-ing the gated channels is a clean mux.
  always_comb begin
    logic [15:0] mux;
    mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_q[i]) mux = mux | slv_drd[16*i +: 16];
    end
    cpu_drd = (sel_q == '0) ? UNMAPPED_DATA : mux;
  end

  logic        unmapped_wr;
  logic        fault_d, fault_q;
  logic [15:0] fault_addr_d, fault_addr_q;
  logic [7:0]  fault_count_d, fault_count_q;

  assign unmapped_wr = (cpu_bwe != 2'b00) && (hit == '0);

  // A clear and a new fault in the same cycle: the clear is applied first.
  always_comb begin
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fault_count_d = fault_count_q;
    if (fault_clear) begin
      fault_d       = 1'b0;
      fault_addr_d  = 16'h0000;
      fault_count_d = 8'h00;
    end
    if (unmapped_wr) begin
      if (!fault_d) begin
        fault_d       = 1'b1;
        fault_addr_d  = cpu_addr;
        fault_count_d = 8'h01;
      end else if (fault_count_d != 8'hff) begin
        fault_count_d = fault_count_d + 8'h01;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q         <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= 16'h0000;
      fault_count_q <= 8'h00;
    end else begin
      sel_q         <= sel_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_cozy_bus_decoder.sv
// Directed bench for cozy_bus_decoder with the default two-channel map:
// ch0 = 0000..1fff, ch1 = ff80..ffff, everything else unmapped.
module tb_cozy_bus_decoder;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [1:0]  cpu_bwe;
  logic [15:0] cpu_drd;
  logic [1:0]  slv_ce;
  logic [3:0]  slv_bwe;
  logic [31:0] slv_drd;
  logic        fault;
  logic [15:0] fault_addr;
  logic [7:0]  fault_count;
  logic        fault_clear;

  int tests_run;
  int tests_failed;

  cozy_bus_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_bwe     (cpu_bwe),
    .cpu_drd     (cpu_drd),
    .slv_ce      (slv_ce),
    .slv_bwe     (slv_bwe),
    .slv_drd     (slv_drd),
    .fault       (fault),
    .fault_addr  (fault_addr),
    .fault_count (fault_count),
    .fault_clear (fault_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_addr = 16'h0010; cpu_bwe = 2'b00; fault_clear = 1'b0;
    slv_drd = {16'h0000, 16'h1234};
    tick(); tick();
    tests_run++; if (cpu_drd !== 16'h0000) begin tests_failed++; $display("FAIL reset_drd: got %h expected %h", cpu_drd, 16'h0000); end
    tests_run++; if (slv_ce !== 2'b01) begin tests_failed++; $display("FAIL reset_ce: got %b expected %b", slv_ce, 2'b01); end
    tests_run++; if ({fault, fault_addr, fault_count} !== 25'h0) begin tests_failed++; $display("FAIL reset_fault: got %b/%h/%h expected 0/0000/00", fault, fault_addr, fault_count); end
    reset = 1'b0;
    #1;
    tests_run++; if (cpu_drd !== 16'h0000) begin tests_failed++; $display("FAIL post_reset_first: got %h expected %h", cpu_drd, 16'h0000); end
    tick();
    tests_run++; if (cpu_drd !== 16'h1234) begin tests_failed++; $display("FAIL read_latency: got %h expected %h", cpu_drd, 16'h1234); end
  endtask

  task automatic test_write_gating();
    cpu_addr = 16'hff82; cpu_bwe = 2'b10;
    #1;
    tests_run++; if (slv_bwe !== 4'b1000) begin tests_failed++; $display("FAIL bwe_ch1_hi: got %b expected %b", slv_bwe, 4'b1000); end
    tests_run++; if (slv_ce !== 2'b10) begin tests_failed++; $display("FAIL ce_ch1: got %b expected %b", slv_ce, 2'b10); end
    cpu_addr = 16'h1fff; cpu_bwe = 2'b11;
    #1;
    tests_run++; if (slv_bwe !== 4'b0011) begin tests_failed++; $display("FAIL bwe_ch0_top: got %b expected %b", slv_bwe, 4'b0011); end
    cpu_addr = 16'h2000; cpu_bwe = 2'b00;
    #1;
    tests_run++; if (slv_ce !== 2'b00) begin tests_failed++; $display("FAIL ce_above_ch0: got %b expected %b", slv_ce, 2'b00); end
    cpu_addr = 16'hff7f;
    #1;
    tests_run++; if (slv_ce !== 2'b00) begin tests_failed++; $display("FAIL ce_below_ch1: got %b expected %b", slv_ce, 2'b00); end
    cpu_addr = 16'hffff; cpu_bwe = 2'b01;
    #1;
    tests_run++; if (slv_bwe !== 4'b0100) begin tests_failed++; $display("FAIL bwe_ch1_lo: got %b expected %b", slv_bwe, 4'b0100); end
    cpu_bwe = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    slv_drd = {16'h5a5a, 16'ha5a5};
    cpu_addr = 16'h0000; tick();
    tests_run++; if (cpu_drd !== 16'ha5a5) begin tests_failed++; $display("FAIL b2b_ch0: got %h expected %h", cpu_drd, 16'ha5a5); end
    cpu_addr = 16'hff80; tick();
    tests_run++; if (cpu_drd !== 16'h5a5a) begin tests_failed++; $display("FAIL b2b_ch1: got %h expected %h", cpu_drd, 16'h5a5a); end
    cpu_addr = 16'h4000; tick();
    tests_run++; if (cpu_drd !== 16'h0000) begin tests_failed++; $display("FAIL b2b_unmapped: got %h expected %h", cpu_drd, 16'h0000); end
    cpu_addr = 16'h0000; tick();
    tests_run++; if (cpu_drd !== 16'ha5a5) begin tests_failed++; $display("FAIL b2b_ch0_again: got %h expected %h", cpu_drd, 16'ha5a5); end
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL unmapped_read_no_fault: got %b expected %b", fault, 1'b0); end
  endtask

  task automatic test_fault_basic();
    cpu_addr = 16'h4000; cpu_bwe = 2'b01;
    #1;
    tests_run++; if (slv_bwe !== 4'b0000) begin tests_failed++; $display("FAIL unmapped_bwe: got %b expected %b", slv_bwe, 4'b0000); end
    tick();
    tests_run++; if ({fault, fault_addr, fault_count} !== {1'b1, 16'h4000, 8'h01}) begin tests_failed++; $display("FAIL fault_first: got %b/%h/%h expected 1/4000/01", fault, fault_addr, fault_count); end
    cpu_addr = 16'h5000; cpu_bwe = 2'b10; tick();
    tests_run++; if ({fault, fault_addr, fault_count} !== {1'b1, 16'h4000, 8'h02}) begin tests_failed++; $display("FAIL fault_second: got %b/%h/%h expected 1/4000/02", fault, fault_addr, fault_count); end
    cpu_addr = 16'h6000; cpu_bwe = 2'b00; tick();
    tests_run++; if ({fault, fault_addr, fault_count} !== {1'b1, 16'h4000, 8'h02}) begin tests_failed++; $display("FAIL fault_unmapped_read: got %b/%h/%h expected 1/4000/02", fault, fault_addr, fault_count); end
    cpu_addr = 16'h0100; cpu_bwe = 2'b11; tick();
    tests_run++; if (fault_count !== 8'h02) begin tests_failed++; $display("FAIL fault_mapped_write: got %h expected %h", fault_count, 8'h02); end
    cpu_bwe = 2'b00; fault_clear = 1'b1; tick();
    fault_clear = 1'b0;
    tests_run++; if ({fault, fault_addr, fault_count} !== 25'h0) begin tests_failed++; $display("FAIL fault_clear_only: got %b/%h/%h expected 0/0000/00", fault, fault_addr, fault_count); end
  endtask

  task automatic test_saturation();
    cpu_addr = 16'h8000; cpu_bwe = 2'b11;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) begin
        tests_run++; if (fault_count !== 8'hfe) begin tests_failed++; $display("FAIL count_254: got %h expected %h", fault_count, 8'hfe); end
      end
      if (i == 255) begin
        tests_run++; if (fault_count !== 8'hff) begin tests_failed++; $display("FAIL count_255: got %h expected %h", fault_count, 8'hff); end
      end
    end
    tests_run++; if ({fault, fault_addr, fault_count} !== {1'b1, 16'h8000, 8'hff}) begin tests_failed++; $display("FAIL count_saturated: got %b/%h/%h expected 1/8000/ff", fault, fault_addr, fault_count); end
  endtask

  task automatic test_clear_with_fault();
    cpu_addr = 16'h7000; cpu_bwe = 2'b11; fault_clear = 1'b1; tick();
    fault_clear = 1'b0; cpu_bwe = 2'b00;
    tests_run++; if ({fault, fault_addr, fault_count} !== {1'b1, 16'h7000, 8'h01}) begin tests_failed++; $display("FAIL clear_and_fault: got %b/%h/%h expected 1/7000/01", fault, fault_addr, fault_count); end
  endtask

  task automatic test_reset_midburst();
    slv_drd = {16'h5a5a, 16'hc0de};
    cpu_addr = 16'h9000; cpu_bwe = 2'b01; tick(); tick();
    cpu_addr = 16'h0000; cpu_bwe = 2'b00; tick();
    tests_run++; if (cpu_drd !== 16'hc0de || fault_count !== 8'h03) begin tests_failed++; $display("FAIL pre_reset_state: got %h/%h expected c0de/03", cpu_drd, fault_count); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if ({fault, fault_addr, fault_count} !== 25'h0) begin tests_failed++; $display("FAIL async_reset_fault: got %b/%h/%h expected 0/0000/00", fault, fault_addr, fault_count); end
    tests_run++; if (cpu_drd !== 16'h0000) begin tests_failed++; $display("FAIL async_reset_drd: got %h expected %h", cpu_drd, 16'h0000); end
    tests_run++; if (slv_ce !== 2'b01) begin tests_failed++; $display("FAIL reset_ce_follows: got %b expected %b", slv_ce, 2'b01); end
    tick();
    reset = 1'b0;
    #1;
    tests_run++; if (cpu_drd !== 16'h0000) begin tests_failed++; $display("FAIL midburst_first_cycle: got %h expected %h", cpu_drd, 16'h0000); end
    tick();
    tests_run++; if (cpu_drd !== 16'hc0de) begin tests_failed++; $display("FAIL midburst_resume: got %h expected %h", cpu_drd, 16'hc0de); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_write_gating();
    test_back_to_back();
    test_fault_basic();
    test_saturation();
    test_clear_with_fault();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
